// File: rtl/active_list_ctrl_if.sv
// Bundle between rename/writeback/flush producers and the active-list controller.
// ACTIVE_LIST_ERR_EN adds the sticky err signal.
interface active_list_ctrl_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) ();
  logic                        alloc_valid;
  logic                        alloc_wb_reg;
  logic [REG_ADDR_WIDTH-1:0]   alloc_virtual_addr;
  logic [REG_ADDR_WIDTH:0]     alloc_physical_addr;
  logic [REG_ADDR_WIDTH:0]     alloc_old_physical_addr;
  logic                        alloc_ready;
  logic [FREE_LIST_WIDTH-1:0]  alloc_index;
  logic                        wb_reg_in;
  logic [FREE_LIST_WIDTH-1:0]  active_list_index_in;
  logic                        flush;
  logic                        commit_valid;
  logic                        commit_wb_reg;
  logic [REG_ADDR_WIDTH-1:0]   commit_virtual_addr;
  logic [REG_ADDR_WIDTH:0]     commit_physical_addr;
  logic [REG_ADDR_WIDTH:0]     free_physical_addr;
  logic                        rollback_valid;
  logic [REG_ADDR_WIDTH-1:0]   rollback_virtual_addr;
  logic [REG_ADDR_WIDTH:0]     rollback_physical_addr;
  logic [REG_ADDR_WIDTH:0]     rollback_old_physical_addr;
  logic                        busy;
  logic [FREE_LIST_WIDTH:0]    count;
`ifdef ACTIVE_LIST_ERR_EN
  logic                        err;
`endif

  modport master (
    output alloc_valid, alloc_wb_reg, alloc_virtual_addr, alloc_physical_addr,
           alloc_old_physical_addr, wb_reg_in, active_list_index_in, flush,
    input  alloc_ready, alloc_index, commit_valid, commit_wb_reg, commit_virtual_addr,
           commit_physical_addr, free_physical_addr, rollback_valid, rollback_virtual_addr,
           rollback_physical_addr, rollback_old_physical_addr, busy, count
`ifdef ACTIVE_LIST_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  alloc_valid, alloc_wb_reg, alloc_virtual_addr, alloc_physical_addr,
           alloc_old_physical_addr, wb_reg_in, active_list_index_in, flush,
    output alloc_ready, alloc_index, commit_valid, commit_wb_reg, commit_virtual_addr,
           commit_physical_addr, free_physical_addr, rollback_valid, rollback_virtual_addr,
           rollback_physical_addr, rollback_old_physical_addr, busy, count
`ifdef ACTIVE_LIST_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/active_list_ctrl.sv
// In-order retirement active list: alloc at tail, commit oldest done entry, youngest-first rollback on flush.
// Commit/rollback pulses are registered; optional sticky err under ACTIVE_LIST_ERR_EN.
module active_list_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  active_list_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam int AW    = REG_ADDR_WIDTH;
  localparam int IW    = FREE_LIST_WIDTH;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] ROLLBACK = 1'b1;

  logic [IW:0]      head_q, head_d, tail_q, tail_d, ptr_q, ptr_d;
  logic [0:0]       state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;

  logic             ent_wb_q    [DEPTH];
  logic [AW-1:0]    ent_vaddr_q [DEPTH];
  logic [AW:0]      ent_paddr_q [DEPTH];
  logic [AW:0]      ent_old_q   [DEPTH];

  logic             cv_q, cv_d, cwb_q, cwb_d, rv_q, rv_d;
  logic [AW-1:0]    cva_q, cva_d, rva_q, rva_d;
  logic [AW:0]      cpa_q, cpa_d, fpa_q, fpa_d, rpa_q, rpa_d, ropa_q, ropa_d;

  logic [IW-1:0]    head_idx, tail_idx, ptr_idx, cmp_idx;
  logic             empty, full, idle, alloc_do;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign ptr_idx  = ptr_q[IW-1:0];
  assign cmp_idx  = bus.active_list_index_in;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign idle     = (state_q == IDLE);
  assign alloc_do = idle && !bus.flush && bus.alloc_valid && !full;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    ptr_d   = ptr_q;
    state_d = state_q;
    valid_d = valid_q;
    done_d  = done_q;
    cv_d = 1'b0; cwb_d = 1'b0; cva_d = '0; cpa_d = '0; fpa_d = '0;
    rv_d = 1'b0; rva_d = '0; rpa_d = '0; ropa_d = '0;
    if (idle) begin
      if (bus.flush) begin
        if (!empty) begin
          state_d = ROLLBACK;
          ptr_d   = tail_q - 1'b1;
        end
      end else begin
        // Uses pre-edge valid, so a completion aimed at the entry being allocated is dropped.
        if (bus.wb_reg_in && valid_q[cmp_idx])
          done_d[cmp_idx] = 1'b1;
        if (valid_q[head_idx] && done_q[head_idx]) begin
          cv_d  = 1'b1;
          cwb_d = ent_wb_q[head_idx];
          cva_d = ent_vaddr_q[head_idx];
          cpa_d = ent_paddr_q[head_idx];
          fpa_d = ent_old_q[head_idx];
          valid_d[head_idx] = 1'b0;
          head_d = head_q + 1'b1;
        end
        if (alloc_do) begin
          valid_d[tail_idx] = 1'b1;
          done_d[tail_idx]  = 1'b0;
          tail_d = tail_q + 1'b1;
        end
      end
    end else begin
      rv_d   = 1'b1;
      rva_d  = ent_vaddr_q[ptr_idx];
      rpa_d  = ent_paddr_q[ptr_idx];
      ropa_d = ent_old_q[ptr_idx];
      valid_d[ptr_idx] = 1'b0;
      if (ptr_q == head_q) begin
        tail_d  = head_q;
        state_d = IDLE;
      end else begin
        ptr_d = ptr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0; tail_q <= '0; ptr_q <= '0; state_q <= IDLE;
      valid_q <= '0; done_q <= '0;
      cv_q <= 1'b0; cwb_q <= 1'b0; cva_q <= '0; cpa_q <= '0; fpa_q <= '0;
      rv_q <= 1'b0; rva_q <= '0; rpa_q <= '0; ropa_q <= '0;
    end else begin
      head_q <= head_d; tail_q <= tail_d; ptr_q <= ptr_d; state_q <= state_d;
      valid_q <= valid_d; done_q <= done_d;
      cv_q <= cv_d; cwb_q <= cwb_d; cva_q <= cva_d; cpa_q <= cpa_d; fpa_q <= fpa_d;
      rv_q <= rv_d; rva_q <= rva_d; rpa_q <= rpa_d; ropa_q <= ropa_d;
    end
  end

  // Payload storage needs no reset: valid bits gate every read.
  always_ff @(posedge clk) begin
    if (alloc_do) begin
      ent_wb_q[tail_idx]    <= bus.alloc_wb_reg;
      ent_vaddr_q[tail_idx] <= bus.alloc_virtual_addr;
      ent_paddr_q[tail_idx] <= bus.alloc_physical_addr;
      ent_old_q[tail_idx]   <= bus.alloc_old_physical_addr;
    end
  end

`ifdef ACTIVE_LIST_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (idle && bus.wb_reg_in && (!valid_q[cmp_idx] || done_q[cmp_idx]))
      err_q <= 1'b1;
  end
  assign bus.err = err_q;
`endif

  assign bus.alloc_ready                = idle && !full;
  assign bus.alloc_index                = tail_idx;
  assign bus.busy                       = (state_q == ROLLBACK);
  assign bus.count                      = tail_q - head_q;
  assign bus.commit_valid               = cv_q;
  assign bus.commit_wb_reg              = cwb_q;
  assign bus.commit_virtual_addr        = cva_q;
  assign bus.commit_physical_addr       = cpa_q;
  assign bus.free_physical_addr         = fpa_q;
  assign bus.rollback_valid             = rv_q;
  assign bus.rollback_virtual_addr      = rva_q;
  assign bus.rollback_physical_addr     = rpa_q;
  assign bus.rollback_old_physical_addr = ropa_q;
endmodule

// File: tb/tb_active_list_ctrl.sv
// Directed self-checking bench for active_list_ctrl; err checks only when ACTIVE_LIST_ERR_EN is defined.
module tb_active_list_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  active_list_ctrl_if #(.REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3)) bus ();
  active_list_ctrl #(.REG_ADDR_WIDTH(5), .FREE_LIST_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int v, input int p, input int o);
    bus.alloc_valid             = 1'b1;
    bus.alloc_wb_reg            = 1'b1;
    bus.alloc_virtual_addr      = 5'(v);
    bus.alloc_physical_addr     = 6'(p);
    bus.alloc_old_physical_addr = 6'(o);
    cyc();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_complete(input int idx);
    bus.wb_reg_in            = 1'b1;
    bus.active_list_index_in = 3'(idx);
    cyc();
    bus.wb_reg_in = 1'b0;
  endtask

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_wb_reg = 1'b0; bus.alloc_virtual_addr = '0;
    bus.alloc_physical_addr = '0; bus.alloc_old_physical_addr = '0;
    bus.wb_reg_in = 1'b0; bus.active_list_index_in = '0; bus.flush = 1'b0;
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_index", bus.alloc_index, 0);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_rollback_valid", bus.rollback_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_free_paddr", bus.free_physical_addr, 0);
`ifdef ACTIVE_LIST_ERR_EN
    chk("rst_err", bus.err, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Fill all 8 entries, then try a 9th.
    for (int i = 0; i < 8; i++) begin
      chk("fill_index", bus.alloc_index, i);
      do_alloc(i + 1, 33 + i, i + 1);
    end
    chk("full_ready", bus.alloc_ready, 0);
    chk("full_count", bus.count, 8);
    do_alloc(9, 60, 9);
    chk("drop_count", bus.count, 8);

    // Out-of-order completion 2,1,0.
    do_complete(2);
    chk("ooo_c2", bus.commit_valid, 0);
    do_complete(1);
    chk("ooo_c1", bus.commit_valid, 0);
    do_complete(0);
    chk("ooo_c0", bus.commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ooo_cv", bus.commit_valid, 1);
      chk("ooo_paddr", bus.commit_physical_addr, 33 + i);
      chk("ooo_free", bus.free_physical_addr, 1 + i);
      chk("ooo_vaddr", bus.commit_virtual_addr, 1 + i);
      chk("ooo_wb", bus.commit_wb_reg, 1);
    end
    chk("ooo_count", bus.count, 5);
    cyc();
    chk("ooo_idle", bus.commit_valid, 0);

    // Drain remaining entries 3..7.
    for (int i = 3; i < 8; i++) begin
      do_complete(i);
      cyc();
      chk("drain_cv", bus.commit_valid, 1);
      chk("drain_paddr", bus.commit_physical_addr, 33 + i);
    end
    chk("drain_count", bus.count, 0);

    // Wrap: 20 allocs with at most 4 in flight, in-order completion.
    for (int k = 0; k < 20; k++) begin
      chk("wrap_index", bus.alloc_index, k % 8);
      do_alloc(k, k + 23, k);
      chk("wrap_count_alloc", bus.count, (k < 3) ? k + 1 : 4);
      if (k >= 3) begin
        do_complete((k - 3) % 8);
        cyc();
        chk("wrap_cv", bus.commit_valid, 1);
        chk("wrap_paddr", bus.commit_physical_addr, k - 3 + 23);
        chk("wrap_free", bus.free_physical_addr, k - 3);
        chk("wrap_count", bus.count, 3);
      end
    end

    // Entries 17,18,19 (paddr 40,41,42) at idx 1,2,3; head made done, then flush+alloc collide.
    do_complete(1);
    chk("sim_pre_cv", bus.commit_valid, 0);
    bus.flush = 1'b1;
    bus.alloc_valid = 1'b1; bus.alloc_virtual_addr = 5'd30;
    bus.alloc_physical_addr = 6'd50; bus.alloc_old_physical_addr = 6'd30;
    cyc();
    bus.flush = 1'b0;
    bus.wb_reg_in = 1'b1; bus.active_list_index_in = 3'd2;
    chk("sim_cv", bus.commit_valid, 0);
    chk("sim_busy", bus.busy, 1);
    chk("sim_ready", bus.alloc_ready, 0);
    chk("sim_rv0", bus.rollback_valid, 0);
    chk("sim_count", bus.count, 3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin
        bus.alloc_valid = 1'b0;
        bus.wb_reg_in = 1'b0;
      end
      chk("rb_valid", bus.rollback_valid, 1);
      chk("rb_paddr", bus.rollback_physical_addr, 42 - i);
      chk("rb_vaddr", bus.rollback_virtual_addr, 19 - i);
      chk("rb_old", bus.rollback_old_physical_addr, 19 - i);
      chk("rb_cv", bus.commit_valid, 0);
      chk("rb_busy", bus.busy, (i < 2) ? 1 : 0);
    end
    chk("post_rb_count", bus.count, 0);
    chk("post_rb_ready", bus.alloc_ready, 1);
    chk("post_rb_index", bus.alloc_index, 1);
    cyc();
    chk("post_rb_rv", bus.rollback_valid, 0);
    chk("post_rb_count2", bus.count, 0);

    // Flush on empty list stays idle.
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("eflush_busy", bus.busy, 0);
    cyc();
    chk("eflush_rv", bus.rollback_valid, 0);

    // Completion to an empty index.
    do_complete(5);
    cyc();
    chk("empty_cmp_cv", bus.commit_valid, 0);
    chk("empty_cmp_count", bus.count, 0);
`ifdef ACTIVE_LIST_ERR_EN
    chk("err_set", bus.err, 1);
    cyc();
    chk("err_sticky", bus.err, 1);
    @(negedge clk) rst_n = 1'b0;
    #2;
    chk("err_rst", bus.err, 0);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/active_list_ctrl.md
Name: active_list_ctrl

Overview:
- In-order retirement controller for the renamed pipeline; owns the 2^FREE_LIST_WIDTH-entry active list.
- Rename stage allocates an entry per instruction. The MEM/WB register's write-back (wb_reg, active_list_index) marks entries done.
- Commits the oldest done entry each cycle and returns the superseded physical register to the free list.
- On flush, walks uncommitted entries youngest-first so the rename map and free list can be rolled back.

Parameters:
- REG_ADDR_WIDTH, 5, architectural (virtual) register address width; physical address is REG_ADDR_WIDTH+1 bits.
- FREE_LIST_WIDTH, 3, active-list index width; depth = 2^FREE_LIST_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- alloc_valid  input  1  rename requests an entry.
- alloc_wb_reg  input  1  instruction writes a register.
- alloc_virtual_addr  input  REG_ADDR_WIDTH  destination architectural register.
- alloc_physical_addr  input  REG_ADDR_WIDTH+1  newly mapped physical register.
- alloc_old_physical_addr  input  REG_ADDR_WIDTH+1  previous mapping of the destination.
- alloc_ready  output  1  entry available, combinational: !full && state==IDLE.
- alloc_index  output  FREE_LIST_WIDTH  index granted, equals current tail, combinational.
- wb_reg_in  input  1  completion strobe from the MEM/WB register.
- active_list_index_in  input  FREE_LIST_WIDTH  index of the completing entry.
- flush  input  1  discard all uncommitted entries.
- commit_valid  output  1  registered one-cycle pulse per retired entry.
- commit_wb_reg  output  1  retired entry wrote a register.
- commit_virtual_addr  output  REG_ADDR_WIDTH  retired architectural register.
- commit_physical_addr  output  REG_ADDR_WIDTH+1  retired physical register.
- free_physical_addr  output  REG_ADDR_WIDTH+1  old physical register to return; valid when commit_valid && commit_wb_reg.
- rollback_valid  output  1  registered pulse per discarded entry.
- rollback_virtual_addr  output  REG_ADDR_WIDTH  map entry to restore.
- rollback_physical_addr  output  REG_ADDR_WIDTH+1  discarded new mapping, returned to the free list.
- rollback_old_physical_addr  output  REG_ADDR_WIDTH+1  mapping to restore.
- busy  output  1  state==ROLLBACK.
- count  output  FREE_LIST_WIDTH+1  occupied entries.

Behaviour:
- Reset (async, rst_n low): head=tail=0, all entry valid/done bits cleared, state=IDLE, every registered output 0.
  - Reset mid-rollback aborts the rollback immediately.
- Pointers are FREE_LIST_WIDTH+1 bits.
  - empty: head==tail.
  - full: index bits equal and MSBs differ.
  - Wrap is natural modulo 2^(FREE_LIST_WIDTH+1).
  - count = tail-head.
- Entry fields: valid, done, wb_reg, vaddr, paddr, old_paddr.
- Allocate, when alloc_valid && alloc_ready: write fields at tail[FREE_LIST_WIDTH-1:0], valid=1, done=0, tail++.
  - alloc_valid while !alloc_ready is dropped; no state change.
- Complete, when wb_reg_in in IDLE: if entry[active_list_index_in].valid, set done=1. Otherwise ignore.
  - A completion to the index allocated the same cycle is ignored.
- Commit, in IDLE only: if head entry valid && done, then next edge:
  - commit_valid=1 and commit fields loaded from the entry.
  - Entry valid cleared, head++.
  - Max one commit per cycle; otherwise commit_valid=0.
  - A completion on the head entry in cycle N commits at edge N+1; commit_valid is seen high after edge N+1, i.e. 1-cycle latency from done to pulse.
- Alloc and commit in the same cycle are both performed; full/empty use pre-edge state, with no bypass.
- Flush, in IDLE, has priority over alloc, complete and commit that cycle.
  - If not empty: state<=ROLLBACK, ptr<=tail-1. Else stay IDLE.
  - All other outputs go 0 next edge.
- ROLLBACK: each cycle emit rollback_* from entry[ptr] with rollback_valid=1, clear its valid.
  - If ptr==head: tail<=head, state<=IDLE. Else ptr--.
  - Discarded entries with wb_reg=0 still pulse rollback_valid; the consumer ignores their addresses.
  - alloc_ready=0. flush and wb_reg_in are ignored. commit_valid=0.
  - Duration = count at flush, in cycles.
- rollback_valid and commit_valid are never high together.

Optional Feature:
- Macro ACTIVE_LIST_ERR_EN.
- Defined: adds output err (1 bit), sticky, cleared only by reset. Set on either of:
  - wb_reg_in in IDLE targeting an invalid entry;
  - wb_reg_in targeting an entry already done.
- Undefined: err port absent; those events are silently ignored. All other behaviour is identical.

Test Plan:
- Reset -> all outputs 0, count=0, alloc_ready=1, alloc_index=0.
- Fill: 8 allocs (v=1..8, p=33..40, old=1..8) -> alloc_ready=0 after the 8th, count=8; a 9th alloc_valid is dropped and count stays 8.
- Out-of-order completion of idx 2, 1, 0 on consecutive cycles -> no commit until idx0 done; then commit_valid 3 consecutive cycles, paddr 33, 34, 35, free_physical_addr 1, 2, 3.
- Wrap: keep 4 entries in flight while allocating 20 total, completing in order -> commits in allocation order; alloc_index wraps 7->0; count never exceeds 8.
- Flush with 3 uncommitted entries (paddr 40, 41, 42) -> busy 3 cycles; rollback_physical_addr 42, 41, 40; then count=0, alloc_ready=1; alloc_valid/wb_reg_in during rollback have no effect.
- Simultaneous: head done with commit, alloc and flush in the same cycle -> flush wins; no commit_valid; rollback starts from the youngest entry. Separately, with ACTIVE_LIST_ERR_EN defined, completing an empty index -> err=1, held until reset.
